// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state encoding and requester IDs for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_AUX  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wdata, mem_we, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection, purely combinational. MEM_ARB_RR_EN defined: tie goes to the requester
// that did not win last; undefined: requester 0 always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    i_req0,
  input  logic    i_req1,
  input  req_id_t i_pointer,
  output req_id_t o_winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    o_winner = REQ_CORE;
    if (i_req0 && i_req1) begin
      o_winner = (i_pointer == REQ_CORE) ? REQ_AUX : REQ_CORE;
    end else if (i_req1) begin
      o_winner = REQ_AUX;
    end
  end
`else
  req_id_t w_unused_pointer;
  assign w_unused_pointer = i_pointer;

  always_comb begin
    o_winner = REQ_CORE;
    if (!i_req0 && i_req1) begin
      o_winner = REQ_AUX;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: IDLE -> ACCESS (gnt) -> RESP (rvalid, reads only).
// Read: gnt at T+1, rvalid at T+2; write: gnt and mem_we at T+1. Tie policy set by MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  req_id_t           r_id;
  req_id_t           r_ptr;
  req_id_t           w_winner;
  logic              w_capture;

  mem_arb_pick u_pick (
    .i_req0    (bus.req0),
    .i_req1    (bus.req1),
    .i_pointer (r_ptr),
    .o_winner  (w_winner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request fields are latched once at capture so later input changes cannot reach the access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_id    <= REQ_CORE;
      r_ptr   <= REQ_AUX;
    end else begin
      if (w_capture) begin
        r_id    <= w_winner;
        r_ptr   <= w_winner;
        r_we    <= (w_winner == REQ_AUX) ? bus.we1    : bus.we0;
        r_addr  <= (w_winner == REQ_AUX) ? bus.addr1  : bus.addr0;
        r_wdata <= (w_winner == REQ_AUX) ? bus.wdata1 : bus.wdata0;
      end
      if (r_state == RESP) begin
        r_rdata <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.rvalid0   = 1'b0;
    bus.rvalid1   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.busy      = 1'b0;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
    bus.rdata     = r_rdata;
    case (r_state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_capture   = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        bus.busy    = 1'b1;
        bus.mem_we  = r_we;
        bus.gnt0    = (r_id == REQ_CORE);
        bus.gnt1    = (r_id == REQ_AUX);
        w_state_nxt = r_we ? IDLE : RESP;
      end
      RESP: begin
        // Memory returns data one cycle after the address, i.e. during this state.
        bus.busy    = 1'b1;
        bus.rdata   = bus.mem_rdata;
        bus.rvalid0 = (r_id == REQ_CORE);
        bus.rvalid1 = (r_id == REQ_AUX);
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have ports req0/req1, input, 1 each, access request from requester 0 (core) and requester 1 (auxiliary: DMA/video).
REQ-006 SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_W each, and wdata0/wdata1, input, DATA_W each, the access address and write data.
REQ-008 SHALL have ports gnt0/gnt1, output, 1 each, one-cycle pulse: the request was captured.
REQ-009 SHALL have ports rvalid0/rvalid1, output, 1 each, and rdata, output, DATA_W, read-data return.
REQ-010 SHALL have ports mem_addr, output, ADDR_W; mem_wdata, output, DATA_W; mem_we, output, 1; mem_rdata, input, DATA_W; connected to the single-port memory.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, ACCESS and RESP.
REQ-013 In IDLE with any reqN high, SHALL pick a winner (REQ-022), capture its we/addr/wdata into internal registers, and enter ACCESS the next cycle.
REQ-014 In IDLE with no request, SHALL stay in IDLE; mem_we = 0.
REQ-015 In ACCESS, SHALL drive mem_addr/mem_wdata/mem_we from the captured registers and pulse the winner's gntN for exactly that cycle.
REQ-016 From ACCESS, a write SHALL return to IDLE; a read SHALL go to RESP.
REQ-017 In RESP, SHALL present rdata = mem_rdata (1-cycle memory read latency) and pulse the winner's rvalidN for one cycle, then return to IDLE.
REQ-018 Latency: read request seen in IDLE at cycle T gives gnt at T+1 and rvalid at T+2; write gives gnt at T+1 with mem_we high in T+1; next capture no earlier than T+2 (write) or T+3 (read).
REQ-019 Requester inputs SHALL be ignored outside IDLE; changing or dropping reqN after capture SHALL NOT affect the access in flight.
REQ-020 A request dropped before it is captured SHALL be discarded without a gnt.
REQ-021 At most one gntN and at most one rvalidN SHALL be high in any cycle; mem_we SHALL be high only in ACCESS.
REQ-022 Simultaneous req0 and req1: winner per REQ-026/REQ-027; a single request always wins.
REQ-023 rdata SHALL hold its last value between rvalid pulses.

Reset
REQ-024 With rst_n low at a clock edge: state = IDLE; gnt0/1, rvalid0/1, mem_we, busy = 0; mem_addr, mem_wdata, rdata = 0; last-winner pointer = 1.
REQ-025 Reset asserted in ACCESS or RESP SHALL abort the access: no gnt or rvalid is issued afterwards for it.

Configuration
REQ-026 With MEM_ARB_RR_EN defined: round-robin; on a tie the requester other than the last winner wins; the pointer updates at each capture.
REQ-027 Without MEM_ARB_RR_EN: fixed priority; on a tie requester 0 always wins; the pointer is unused.

Structure
REQ-028 Package mem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10) and requester IDs (REQ_CORE=0, REQ_AUX=1).
REQ-029 Winner selection SHALL be sub-module mem_arb_pick (inputs: req0, req1, pointer; output: winner id); everything else stays in mem_arbiter.

Verification
REQ-030 Lone read: req0=1, we0=0, addr0=24'h004000 in IDLE -> gnt0 at T+1 with mem_addr=24'h004000, mem_we=0; rvalid0 at T+2 with rdata = mem_rdata (e.g. 16'hA5A5).
REQ-031 Lone write: req1=1, we1=1, addr1=24'h000010, wdata1=16'h1234 -> T+1 mem_we=1, mem_addr=24'h000010, mem_wdata=16'h1234, gnt1=1; no rvalid1.
REQ-032 Tie, both reads held high for 4 accesses -> RR_EN: grants alternate 0,1,0,1; without RR_EN: grants 0,0,0,0.
REQ-033 After capture of addr0=24'h000100, change addr0 to 24'h000200 -> mem_addr stays 24'h000100 in ACCESS.
REQ-034 rst_n low in ACCESS of a read -> next cycle IDLE, busy=0, mem_we=0; no rvalid pulse.
REQ-035 Checker throughout: never two gnt, never two rvalid, and mem_we never high outside ACCESS.
